// File: rtl/plugboard_stage_if.sv
// Handshake and pair-load bundle between the plugboard stage and its driver.
// The master drives characters and swap pairs; the slave returns substituted bytes and status.
interface plugboard_stage_if #(
    parameter int CW = 4
);
    logic          clear;
    logic          pair_wr;
    logic [7:0]    pair_a;
    logic [7:0]    pair_b;
    logic          valid;
    logic [7:0]    din;
    logic [7:0]    dout;
    logic          done;
    logic          busy;
    logic [CW-1:0] pair_cnt;
    logic          err;

    modport master (
        output clear, pair_wr, pair_a, pair_b, valid, din,
        input  dout, done, busy, pair_cnt, err
    );

    modport slave (
        input  clear, pair_wr, pair_a, pair_b, valid, din,
        output dout, done, busy, pair_cnt, err
    );
endinterface

// File: rtl/plugboard_stage.sv
// Enigma plugboard: reciprocal letter-swap table with a checked pair-load port
// and a three-state lookup FSM feeding the rotor stage.
module plugboard_stage #(
    parameter int MAX_PAIRS = 10,
    parameter int CW        = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    plugboard_stage_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, LOOK = 2'd1, DONE = 2'd2} state_t;

    state_t          state_q;
    logic [25:0][4:0] map_q;
    logic [7:0]      din_q;
    logic [7:0]      dout_q;
    logic            done_q;
    logic            busy_q;
    logic            err_q;
    logic [CW-1:0]   cnt_q;

    function automatic logic [25:0][4:0] identity_map();
        logic [25:0][4:0] m;
        for (int i = 0; i < 26; i++) m[i] = 5'(i);
        return m;
    endfunction

    function automatic logic is_letter(input logic [7:0] c);
        return (c >= 8'd65) && (c <= 8'd90);
    endfunction

    logic       a_in, b_in, d_in, a_free, b_free, wr_ok;
    logic [4:0] a_idx, b_idx, d_idx;
    logic [7:0] look_val;

    assign a_in  = is_letter(bus.pair_a);
    assign b_in  = is_letter(bus.pair_b);
    assign d_in  = is_letter(din_q);
    assign a_idx = 5'(bus.pair_a - 8'd65);
    assign b_idx = 5'(bus.pair_b - 8'd65);
    assign d_idx = 5'(din_q - 8'd65);

    // Table reads are masked by the range checks so a non-letter never indexes map_q.
    assign a_free   = a_in ? (map_q[a_idx] == a_idx) : 1'b0;
    assign b_free   = b_in ? (map_q[b_idx] == b_idx) : 1'b0;
    assign look_val = d_in ? (8'd65 + {3'b000, map_q[d_idx]}) : din_q;

    assign wr_ok = bus.pair_wr && !bus.clear && (state_q == IDLE) &&
                   a_in && b_in && (a_idx != b_idx) && a_free && b_free &&
                   (cnt_q < CW'(MAX_PAIRS));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            map_q   <= identity_map();
            din_q   <= 8'h00;
            dout_q  <= 8'h00;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            // A pair_wr that loses to clear is dropped without an error.
            err_q  <= bus.pair_wr && !bus.clear && !wr_ok;
            done_q <= 1'b0;

            if (bus.clear) begin
                map_q <= identity_map();
                cnt_q <= '0;
            end else if (wr_ok) begin
                map_q[a_idx] <= b_idx;
                map_q[b_idx] <= a_idx;
                cnt_q        <= cnt_q + 1'b1;
            end

            case (state_q)
                IDLE: if (bus.valid) begin
                    din_q   <= bus.din;
                    busy_q  <= 1'b1;
                    state_q <= LOOK;
                end
                LOOK: begin
                    dout_q  <= look_val;
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.dout     = dout_q;
    assign bus.done     = done_q;
    assign bus.busy     = busy_q;
    assign bus.err      = err_q;
    assign bus.pair_cnt = cnt_q;
endmodule

// File: tb/tb_plugboard_stage.sv
// Directed bench for plugboard_stage: lookups, pair legality, clear and reset cases.
module tb_plugboard_stage;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    plugboard_stage_if #(.CW(4)) bus ();

    plugboard_stage #(.MAX_PAIRS(10), .CW(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic lookup(input string tag, input logic [7:0] ch, input logic [7:0] exp);
        @(negedge clk);
        bus.valid = 1'b1;
        bus.din   = ch;
        @(negedge clk);
        bus.valid = 1'b0;
        chk({tag, "_look_busy"}, 32'(bus.busy), 32'd1);
        chk({tag, "_look_done"}, 32'(bus.done), 32'd0);
        @(negedge clk);
        chk({tag, "_done"}, 32'(bus.done), 32'd1);
        chk({tag, "_dout"}, 32'(bus.dout), 32'(exp));
        @(negedge clk);
        chk({tag, "_done_end"}, 32'(bus.done), 32'd0);
        chk({tag, "_busy_end"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic put_pair(input string tag, input logic [7:0] a, input logic [7:0] b,
                            input logic exp_err, input int exp_cnt);
        @(negedge clk);
        bus.pair_wr = 1'b1;
        bus.pair_a  = a;
        bus.pair_b  = b;
        @(negedge clk);
        bus.pair_wr = 1'b0;
        chk({tag, "_err"}, 32'(bus.err), 32'(exp_err));
        chk({tag, "_cnt"}, 32'(bus.pair_cnt), 32'(exp_cnt));
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
    endtask

    initial begin
        bus.clear = 1'b0; bus.pair_wr = 1'b0; bus.pair_a = 8'd0; bus.pair_b = 8'd0;
        bus.valid = 1'b0; bus.din = 8'd0;
        repeat (2) @(negedge clk);
        chk("rst_dout", 32'(bus.dout), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_err",  32'(bus.err),  32'd0);
        chk("rst_cnt",  32'(bus.pair_cnt), 32'd0);
        reset_n = 1'b1;

        lookup("E_ident", 8'd69, 8'd69);
        chk("E_cnt", 32'(bus.pair_cnt), 32'd0);

        put_pair("AZ", 8'd65, 8'd90, 1'b0, 1);
        lookup("A_to_Z", 8'd65, 8'd90);
        lookup("Z_to_A", 8'd90, 8'd65);

        put_pair("AB_plugged", 8'd65, 8'd66, 1'b1, 1);
        put_pair("QQ_same",    8'd81, 8'd81, 1'b1, 1);
        put_pair("1C_range",   8'd49, 8'd67, 1'b1, 1);
        lookup("B_ident", 8'd66, 8'd66);
        lookup("C_ident", 8'd67, 8'd67);

        // Nine more disjoint pairs bring the count to the limit.
        for (int i = 0; i < 9; i++)
            put_pair("fill", 8'(66 + 2 * i), 8'(67 + 2 * i), 1'b0, 2 + i);
        put_pair("TU_full", 8'd84, 8'd85, 1'b1, 10);
        lookup("R_to_S", 8'd82, 8'd83);
        pulse_clear();
        chk("clr_cnt", 32'(bus.pair_cnt), 32'd0);
        lookup("A_cleared", 8'd65, 8'd65);
        put_pair("TU_after_clr", 8'd84, 8'd85, 1'b0, 1);
        lookup("T_to_U", 8'd84, 8'd85);

        lookup("lower_a", 8'd97, 8'd97);
        lookup("space",   8'd32, 8'd32);

        // valid held through LOOK and DONE must not start a second lookup.
        @(negedge clk);
        bus.valid = 1'b1; bus.din = 8'd85;
        @(negedge clk);
        @(negedge clk);
        chk("hold_done", 32'(bus.done), 32'd1);
        chk("hold_dout", 32'(bus.dout), 32'd84);
        @(negedge clk);
        bus.valid = 1'b0;
        chk("hold_done_e3", 32'(bus.done), 32'd0);
        @(negedge clk);
        chk("hold_done_e4", 32'(bus.done), 32'd0);
        chk("hold_busy_e4", 32'(bus.busy), 32'd0);
        @(negedge clk);
        chk("hold_done_e5", 32'(bus.done), 32'd0);

        // Clear landing on the LOOK edge still sees the old table.
        @(negedge clk);
        bus.valid = 1'b1; bus.din = 8'd84;
        @(negedge clk);
        bus.valid = 1'b0; bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        chk("clrlook_done", 32'(bus.done), 32'd1);
        chk("clrlook_dout", 32'(bus.dout), 32'd85);
        chk("clrlook_cnt",  32'(bus.pair_cnt), 32'd0);
        @(negedge clk);
        lookup("T_after_clr", 8'd84, 8'd84);

        // clear wins over a same-cycle pair_wr, silently.
        @(negedge clk);
        bus.clear = 1'b1; bus.pair_wr = 1'b1; bus.pair_a = 8'd65; bus.pair_b = 8'd66;
        @(negedge clk);
        bus.clear = 1'b0; bus.pair_wr = 1'b0;
        chk("clrwr_err", 32'(bus.err), 32'd0);
        chk("clrwr_cnt", 32'(bus.pair_cnt), 32'd0);

        // Same-edge pair write and din latch: lookup sees the new pair.
        @(negedge clk);
        bus.valid = 1'b1; bus.din = 8'd67;
        bus.pair_wr = 1'b1; bus.pair_a = 8'd67; bus.pair_b = 8'd68;
        @(negedge clk);
        bus.valid = 1'b0; bus.pair_wr = 1'b0;
        chk("simul_err", 32'(bus.err), 32'd0);
        @(negedge clk);
        chk("simul_done", 32'(bus.done), 32'd1);
        chk("simul_dout", 32'(bus.dout), 32'd68);
        chk("simul_cnt",  32'(bus.pair_cnt), 32'd1);
        @(negedge clk);

        // Reset in LOOK aborts the lookup and restores identity.
        put_pair("TU_again", 8'd84, 8'd85, 1'b0, 2);
        @(negedge clk);
        bus.valid = 1'b1; bus.din = 8'd84;
        @(negedge clk);
        bus.valid = 1'b0;
        chk("abort_busy_pre", 32'(bus.busy), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("abort_dout", 32'(bus.dout), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_cnt",  32'(bus.pair_cnt), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_no_done", 32'(bus.done), 32'd0);
        end
        lookup("T_after_rst", 8'd84, 8'd84);
        lookup("C_after_rst", 8'd67, 8'd67);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/plugboard_stage.md
Name: plugboard_stage

Overview:
- Enigma plugboard (Steckerbrett) stage, directly upstream of the rotor stage.
- Holds up to MAX_PAIRS reciprocal letter swaps and substitutes each incoming ASCII character through the swap table.
- Produces a registered output byte plus a one-cycle done pulse; the next stage takes these as its din/valid.
- Swap pairs are loaded one per cycle through a write port with full legality checking.

Parameters:
MAX_PAIRS, 10, maximum simultaneous swap pairs (1..13)
CW, 4, width of pair_cnt; must satisfy 2^CW > MAX_PAIRS

Ports:
clk  input  1  clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
clear  input  1  restore identity table, pair_cnt to 0
pair_wr  input  1  request to add swap pair_a<->pair_b
pair_a  input  8  ASCII letter, first of pair
pair_b  input  8  ASCII letter, second of pair
valid  input  1  din carries a character to substitute
din  input  8  ASCII input character
dout  output  8  substituted character, valid while done=1, held afterwards
done  output  1  one-cycle pulse: dout updated
busy  output  1  high in LOOK and DONE states
pair_cnt  output  CW  number of installed pairs
err  output  1  one-cycle pulse: pair_wr rejected

Behaviour:
- Reset (async, reset_n=0): map[i]=i for i=0..25; state IDLE; dout=8'h00; done=0; busy=0; err=0; pair_cnt=0. Reset mid-lookup aborts the lookup with no done pulse.
- Table: 26 entries of 5 bits, indexed by letter-65. Invariant: map is an involution (map[map[i]]==i).
- FSM:
  - IDLE: valid=1 latches din, goes to LOOK. valid=0 stays in IDLE.
  - LOOK: at the next edge, dout <= map[din-65] if din is in 'A'..'Z' (65..90), else dout <= din unchanged. done <= 1, go to DONE.
  - DONE: done=1 for exactly this cycle, then IDLE.
  - valid is ignored outside IDLE; no queuing. Latency is valid-edge to done=2 cycles; throughput is 1 per 3 cycles.
- pair_wr is accepted (effective at the edge) only if all of the following hold; otherwise err=1 for one cycle and there is no table change:
  - state==IDLE and clear=0;
  - pair_a and pair_b are both in 65..90, and pair_a!=pair_b;
  - map[pair_a-65]==pair_a-65 and map[pair_b-65]==pair_b-65 (both letters unplugged);
  - pair_cnt<MAX_PAIRS.
- Accepted write: map[a] <= b, map[b] <= a, pair_cnt <= pair_cnt+1.
- clear: takes effect at the edge in any state and has priority over pair_wr (a pair_wr in the same cycle is dropped silently, err=0).
  - An in-flight lookup whose LOOK edge coincides with the clear edge uses the pre-clear table.
  - A lookup whose LOOK edge is later uses the cleared table.
- Simultaneous valid and accepted pair_wr in IDLE: the table write and the din latch happen at the same edge; the LOOK-edge lookup uses the updated table.
- Arithmetic: the index is din-65 truncated to 5 bits, used only after the 65..90 range check. No out-of-range table access.

Test Plan:
- Reset, then valid din='E'(69) -> done pulse exactly 2 edges later, dout=69, busy high 2 cycles, pair_cnt=0.
- pair_wr A/Z, then valid din='A' -> dout='Z'(90); valid din='Z' -> dout='A'(65); pair_cnt=1, err=0.
- After A/Z: pair_wr A/B -> err pulse, pair_cnt stays 1. pair_wr Q/Q -> err. pair_wr '1'(49)/C -> err. Table unchanged ('B'->'B').
- Install MAX_PAIRS(10) legal pairs, then an 11th legal pair -> err, pair_cnt=10. clear -> pair_cnt=0, 'A'->'A'; the same 11th pair is then accepted.
- valid din='a'(97) and din=' '(32) -> dout=97 and dout=32 respectively, done pulses; valid asserted during LOOK/DONE produces no extra done.
- Assert reset_n=0 in the LOOK state -> no done pulse; dout=0, busy=0, and the table returns to identity immediately.
